// File: rtl/dmem_pkg.sv
// Shared encodings, request record and byte-lane helpers for the data-memory responder.
package dmem_pkg;

  // Access size, taken from funct3[1:0] of the load/store instruction.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  // Responder FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // One captured request.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        write;
    logic        is_signed;
  } req_t;

  // Byte-lane write mask for an access of the given size at the given byte offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicates right-justified store data across all lanes so any enabled lane sees its bytes.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_B:    d = {4{wdata[7:0]}};
      SZ_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 data array: byte-enabled synchronous write, combinational read.
module dmem_ram import dmem_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_q [DEPTH];

  // Commit each enabled byte lane; disabled lanes keep their old contents.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the core load/store interface: one request at a time, fixed latency,
// aligned/extended loads, byte-masked stores and fault detection.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic        i_isLoadSigned,
  output logic        o_memReady,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  localparam int   AW   = $clog2(DEPTH);
  localparam int   CW   = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic LAT0 = (LATENCY == 0);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [31:0]   rdata_q, rdata_d;

  req_t          cur_s;
  logic          accept_s;
  logic          enter_resp_s;
  logic          size_fault_s;
  logic          range_fault_s;
  logic          fault_s;
  logic          we_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   ram_rdata_s;
  logic [31:0]   load_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;

  assign accept_s = i_memReq && ready_q;

  // Request being worked on: live inputs while idle (zero-latency path), captured copy afterwards.
  always_comb begin
    cur_s = req_q;
    if (state_q == ST_IDLE) begin
      cur_s = '{addr: i_addr, wdata: i_wdata, size: i_size,
                write: i_memWrite, is_signed: i_isLoadSigned};
    end else begin
      cur_s = req_q;
    end
  end

  // Alignment / illegal-size check; high address bits are not aliased, they fault.
  always_comb begin
    size_fault_s = 1'b0;
    case (cur_s.size)
      SZ_B:    size_fault_s = 1'b0;
      SZ_H:    size_fault_s = cur_s.addr[0];
      SZ_W:    size_fault_s = |cur_s.addr[1:0];
      default: size_fault_s = 1'b1;
    endcase
  end

  assign range_fault_s = |cur_s.addr[31:AW+2];
  assign fault_s       = size_fault_s || range_fault_s;
  assign idx_s         = cur_s.addr[AW+1:2];

  // Next-state, counter and request-capture logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          req_d = cur_s;
          cnt_d = CW'(LATENCY);
          if (LAT0) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d      = ST_RESP;
          cnt_d        = '0;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pick the addressed byte/half out of the RAM word and extend it.
  always_comb begin
    byte_s = ram_rdata_s[{cur_s.addr[1:0], 3'b000} +: 8];
    half_s = cur_s.addr[1] ? ram_rdata_s[31:16] : ram_rdata_s[15:0];
    load_s = 32'h0000_0000;
    case (cur_s.size)
      SZ_B:    load_s = {{24{cur_s.is_signed & byte_s[7]}}, byte_s};
      SZ_H:    load_s = {{16{cur_s.is_signed & half_s[15]}}, half_s};
      SZ_W:    load_s = ram_rdata_s;
      default: load_s = 32'h0000_0000;
    endcase
  end

  // Response outputs are computed on the edge entering RESP and are zero in every other state.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    done_d  = enter_resp_s;
    fault_d = enter_resp_s && fault_s;
    rdata_d = 32'h0000_0000;
    if (enter_resp_s && !fault_s && !cur_s.write) begin
      rdata_d = load_s;
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // The store lands on the RESP-entry edge, so a reset during WAIT cancels it.
  assign we_s = enter_resp_s && cur_s.write && !fault_s;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (we_s),
    .i_be    (byte_en(cur_s.size, cur_s.addr[1:0])),
    .i_addr  (idx_s),
    .i_wdata (lane_data(cur_s.size, cur_s.wdata)),
    .o_rdata (ram_rdata_s)
  );

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_memReady = ready_q;
  assign o_done     = done_q;
  assign o_rdata    = rdata_q;
  assign o_fault    = fault_q;

endmodule
